plot_queue: RTL and testbench

//  Downstream stage of the rectangle rasteriser in the paint datapath. Buffers the
//  (x, y, colour) pixel stream it produces and drives the VGA adapter plot port at
//  one pixel per cycle. Decouples rasteriser rate from adapter write gating, e.g.

---
 rtl/plot_queue_pkg.sv | 17 +
 rtl/plot_queue_if.sv | 44 ++++
 rtl/plot_queue_sync_fifo.sv | 58 +++++
 rtl/plot_queue.sv | 119 +++++++++++
 tb/tb_plot_queue.sv | 264 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/plot_queue_pkg.sv
// Shared paint-datapath types and widths.
// Exports COORD_W, VGA_Y_W, default screen size and pixel_t.
package plot_queue_pkg;

    localparam int COORD_W      = 8;
    localparam int VGA_Y_W      = 7;
    localparam int XMAX_DEF     = 160;
    localparam int YMAX_DEF     = 120;
    localparam int COLOUR_W_DEF = 3;

    typedef struct packed {
        logic [COORD_W-1:0]      x;
        logic [COORD_W-1:0]      y;
        logic [COLOUR_W_DEF-1:0] colour;
    } pixel_t;

endpackage

// File: rtl/plot_queue_if.sv
// Pixel-in / VGA-plot-out bundle of the plot queue.
// master: rasteriser + adapter side; slave: plot_queue.
// Carries drop_count only when PLOT_QUEUE_CLIP_EN is defined.
interface plot_queue_if #(
    parameter int DEPTH    = 16,
    parameter int COLOUR_W = 3
);
    import plot_queue_pkg::*;

    logic                   in_valid;
    logic [COORD_W-1:0]     in_x;
    logic [COORD_W-1:0]     in_y;
    logic [COLOUR_W-1:0]    in_colour;
    logic                   in_ready;
    logic                   plot_en;
    logic [COORD_W-1:0]     vga_x;
    logic [VGA_Y_W-1:0]     vga_y;
    logic [COLOUR_W-1:0]    vga_colour;
    logic                   vga_plot;
    logic                   empty;
    logic [$clog2(DEPTH):0] count;
`ifdef PLOT_QUEUE_CLIP_EN
    logic [7:0]             drop_count;
`endif

    modport master (
        output in_valid, in_x, in_y, in_colour, plot_en,
        input  in_ready, vga_x, vga_y, vga_colour,
        input  vga_plot, empty, count
`ifdef PLOT_QUEUE_CLIP_EN
        , input drop_count
`endif
    );

    modport slave (
        input  in_valid, in_x, in_y, in_colour, plot_en,
        output in_ready, vga_x, vga_y, vga_colour,
        output vga_plot, empty, count
`ifdef PLOT_QUEUE_CLIP_EN
        , output drop_count
`endif
    );

endinterface

// File: rtl/plot_queue_sync_fifo.sv
// Single-clock FIFO, DEPTH a power of two.
// Ports: i_push/i_wdata, i_pop/o_rdata (show-ahead), o_full, o_empty, o_count.
module plot_queue_sync_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   i_push,
    input  logic [WIDTH-1:0]       i_wdata,
    input  logic                   i_pop,
    output logic [WIDTH-1:0]       o_rdata,
    output logic                   o_full,
    output logic                   o_empty,
    output logic [$clog2(DEPTH):0] o_count
);
    localparam int            AW       = $clog2(DEPTH);
    localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_push;
    logic             w_pop;

    assign o_full  = (r_count == FULL_CNT);
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_rdata = r_mem[r_rd_ptr];

    // A push into a full FIFO is dropped even if a pop frees a slot.
    assign w_push = i_push & ~o_full;
    assign w_pop  = i_pop & ~o_empty;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/plot_queue.sv
// Buffers the rasteriser pixel stream and drives the VGA plot port,
// one pixel per cycle while plot_en is high.
// Ports: clk, reset (async, active-high), bus (plot_queue_if.slave).
// Option PLOT_QUEUE_CLIP_EN: drop off-screen pixels, count in drop_count.
module plot_queue
    import plot_queue_pkg::*;
#(
    parameter int DEPTH    = 16,
    parameter int XMAX     = XMAX_DEF,
    parameter int YMAX     = YMAX_DEF,
    parameter int COLOUR_W = COLOUR_W_DEF
) (
    input  logic       clk,
    input  logic       reset,
    plot_queue_if.slave bus
);
    localparam int AW = $clog2(DEPTH);

    // Only the low VGA_Y_W bits of y ever reach the adapter.
    typedef struct packed {
        logic [COORD_W-1:0]  x;
        logic [VGA_Y_W-1:0]  y;
        logic [COLOUR_W-1:0] colour;
    } entry_t;

    entry_t              w_wr;
    entry_t              w_rd;
    logic                w_full;
    logic                w_fempty;
    logic [AW:0]         w_count;
    logic                w_xfer;
    logic                w_clip;
    logic                w_push;
    logic                w_pop;

    logic                r_plot;
    logic [COORD_W-1:0]  r_x;
    logic [VGA_Y_W-1:0]  r_y;
    logic [COLOUR_W-1:0] r_colour;

    assign bus.in_ready = ~w_full;
    assign w_xfer       = bus.in_valid & ~w_full;

`ifdef PLOT_QUEUE_CLIP_EN
    localparam logic [COORD_W:0] XLIM = (COORD_W+1)'(XMAX);
    localparam logic [COORD_W:0] YLIM = (COORD_W+1)'(YMAX);

    logic [7:0] r_drop;

    // Clipped pixels still complete the handshake.
    assign w_clip = ({1'b0, bus.in_x} >= XLIM)
                  | ({1'b0, bus.in_y} >= YLIM);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_drop <= '0;
        end else if (w_xfer && w_clip && r_drop != 8'hFF) begin
            r_drop <= r_drop + 8'd1;
        end
    end

    assign bus.drop_count = r_drop;
`else
    logic w_unused;

    assign w_clip   = 1'b0;
    assign w_unused = ^{bus.in_y[COORD_W-1], XMAX[0], YMAX[0]};
`endif

    assign w_push = w_xfer & ~w_clip;
    assign w_pop  = ~w_fempty & bus.plot_en;

    always_comb begin
        w_wr        = '0;
        w_wr.x      = bus.in_x;
        w_wr.y      = bus.in_y[VGA_Y_W-1:0];
        w_wr.colour = bus.in_colour;
    end

    plot_queue_sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH ($bits(entry_t))
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_push),
        .i_wdata (w_wr),
        .i_pop   (w_pop),
        .o_rdata (w_rd),
        .o_full  (w_full),
        .o_empty (w_fempty),
        .o_count (w_count)
    );

    // Output registers hold the last pixel between strobes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_plot   <= 1'b0;
            r_x      <= '0;
            r_y      <= '0;
            r_colour <= '0;
        end else begin
            r_plot <= w_pop;
            if (w_pop) begin
                r_x      <= w_rd.x;
                r_y      <= w_rd.y;
                r_colour <= w_rd.colour;
            end
        end
    end

    assign bus.vga_plot   = r_plot;
    assign bus.vga_x      = r_x;
    assign bus.vga_y      = r_y;
    assign bus.vga_colour = r_colour;
    assign bus.count      = w_count;
    assign bus.empty      = w_fempty & ~r_plot;

endmodule

// File: tb/tb_plot_queue.sv
// Self-checking bench for plot_queue: vector table, scoreboard
// of expected strobes, and directed multi-cycle sequences.
module tb_plot_queue;
    import plot_queue_pkg::*;

    localparam int DEPTH = 16;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    plot_queue_if #(.DEPTH(DEPTH), .COLOUR_W(3)) bus ();

    plot_queue #(
        .DEPTH    (DEPTH),
        .XMAX     (160),
        .YMAX     (120),
        .COLOUR_W (3)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int          npass    = 0;
    int          ntotal   = 0;
    int          n_strobe = 0;
    logic [17:0] exp_q[$];
    logic [17:0] mon_e;

    typedef struct {
        logic [7:0]  x;
        logic [7:0]  y;
        logic [2:0]  c;
        logic [17:0] exp;
    } row_t;

    row_t rows[5];

    task automatic check(input string name, input int act, input int exp);
        ntotal++;
        if (act == exp) npass++;
        else $display("FAIL %s: got %0d want %0d", name, act, exp);
    endtask

    function automatic logic [17:0] pix(input logic [7:0] x,
                                        input logic [7:0] y,
                                        input logic [2:0] c);
        return {x, y[6:0], c};
    endfunction

    function automatic bit stored(input logic [7:0] x, input logic [7:0] y);
`ifdef PLOT_QUEUE_CLIP_EN
        return (x < 8'd160) && (y < 8'd120);
`else
        return (x == x) && (y == y);
`endif
    endfunction

    always @(posedge clk) begin
        #1;
        if (bus.vga_plot === 1'b1) begin
            n_strobe++;
            if (exp_q.size() == 0) begin
                check("strobe_unexpected", 1, 0);
            end else begin
                mon_e = exp_q.pop_front();
                check("strobe_pixel",
                      int'({bus.vga_x, bus.vga_y, bus.vga_colour}),
                      int'(mon_e));
            end
        end
    end

    // Call at a negedge; returns at a later negedge with in_valid low.
    task automatic drive_px(input logic [7:0] x, input logic [7:0] y,
                            input logic [2:0] c, input int max_wait);
        int waited;
        waited        = 0;
        bus.in_valid  = 1'b1;
        bus.in_x      = x;
        bus.in_y      = y;
        bus.in_colour = c;
        forever begin
            #1;
            if (bus.in_ready) begin
                if (stored(x, y)) exp_q.push_back(pix(x, y, c));
                @(negedge clk);
                bus.in_valid = 1'b0;
                return;
            end
            @(negedge clk);
            waited++;
            if (waited > max_wait) begin
                check("push_timeout", 1, 0);
                bus.in_valid = 1'b0;
                return;
            end
        end
    endtask

    task automatic wait_idle(input int max);
        int k;
        k = 0;
        while (!(bus.empty && exp_q.size() == 0) && k < max) begin
            @(negedge clk);
            k++;
        end
        check("drain_scoreboard", exp_q.size(), 0);
        check("drain_empty", int'(bus.empty), 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int s0;
        int max_cnt;
        int i;
        bit acc;

        rows[0] = '{8'd5,   8'd7,   3'd3, {8'd5,   7'd7,   3'd3}};
        rows[1] = '{8'd0,   8'd0,   3'd0, {8'd0,   7'd0,   3'd0}};
        rows[2] = '{8'd159, 8'd119, 3'd7, {8'd159, 7'd119, 3'd7}};
        rows[3] = '{8'd80,  8'd64,  3'd2, {8'd80,  7'd64,  3'd2}};
        rows[4] = '{8'd100, 8'd100, 3'd6, {8'd100, 7'd100, 3'd6}};

        reset         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_x      = '0;
        bus.in_y      = '0;
        bus.in_colour = '0;
        bus.plot_en   = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        // reset state and idle
        check("rst_plot", int'(bus.vga_plot), 0);
        check("rst_xyc", int'({bus.vga_x, bus.vga_y, bus.vga_colour}), 0);
        repeat (50) @(negedge clk);
        check("idle_plot", int'(bus.vga_plot), 0);
        check("idle_empty", int'(bus.empty), 1);
        check("idle_ready", int'(bus.in_ready), 1);
        check("idle_count", int'(bus.count), 0);
        check("idle_strobes", n_strobe, 0);

        // single-pixel latency table
        foreach (rows[r]) begin
            drive_px(rows[r].x, rows[r].y, rows[r].c, 4);
            check("row_count1", int'(bus.count), 1);
            check("row_busy", int'(bus.empty), 0);
            @(negedge clk);
            check("row_plot", int'(bus.vga_plot), 1);
            check("row_pixel",
                  int'({bus.vga_x, bus.vga_y, bus.vga_colour}),
                  int'(rows[r].exp));
            @(negedge clk);
            check("row_plot_off", int'(bus.vga_plot), 0);
            check("row_empty", int'(bus.empty), 1);
        end

        // fill to full, 17th held off, then burst drain
        bus.plot_en = 1'b0;
        for (int k = 0; k < 16; k++) begin
            drive_px(8'(k), 8'd1, 3'(k), 4);
        end
        check("full_count", int'(bus.count), 16);
        check("full_ready", int'(bus.in_ready), 0);
        bus.in_valid  = 1'b1;
        bus.in_x      = 8'd16;
        bus.in_y      = 8'd1;
        bus.in_colour = 3'd0;
        repeat (3) @(negedge clk);
        check("full_hold_count", int'(bus.count), 16);
        check("full_hold_ready", int'(bus.in_ready), 0);
        s0          = n_strobe;
        acc         = 1'b0;
        bus.plot_en = 1'b1;
        for (int k = 0; k < 17; k++) begin
            @(negedge clk);
            if (acc) bus.in_valid = 1'b0;
            check("burst_strobe", int'(bus.vga_plot), 1);
            if (bus.in_valid && bus.in_ready && !acc) begin
                exp_q.push_back(pix(8'd16, 8'd1, 3'd0));
                acc = 1'b1;
            end
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        check("burst_accepted17", int'(acc), 1);
        check("burst_end_plot", int'(bus.vga_plot), 0);
        check("burst_n", n_strobe - s0, 17);
        wait_idle(50);

        // stream 40 with plot_en toggling
        s0      = n_strobe;
        max_cnt = 0;
        i       = 0;
        for (int cyc = 0; cyc < 500 && i < 40; cyc++) begin
            bus.plot_en   = (cyc % 2 == 0);
            bus.in_valid  = 1'b1;
            bus.in_x      = 8'(i + 20);
            bus.in_y      = 8'(i + 2);
            bus.in_colour = 3'(i);
            if (bus.in_ready) begin
                exp_q.push_back(pix(8'(i + 20), 8'(i + 2), 3'(i)));
                i++;
            end
            if (int'(bus.count) > max_cnt) max_cnt = int'(bus.count);
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        bus.plot_en  = 1'b1;
        check("stream_sent", i, 40);
        wait_idle(200);
        check("stream_n", n_strobe - s0, 40);
        check("stream_max_le_depth", int'(max_cnt <= DEPTH), 1);
        check("stream_reached_full", max_cnt, DEPTH);

        // off-screen pixels
        s0 = n_strobe;
        drive_px(8'd160, 8'd0, 3'd1, 4);
        drive_px(8'd0, 8'd120, 3'd2, 4);
        drive_px(8'd159, 8'd119, 3'd5, 4);
        wait_idle(20);
`ifdef PLOT_QUEUE_CLIP_EN
        check("clip_n", n_strobe - s0, 1);
        check("clip_drops", int'(bus.drop_count), 2);
`else
        check("noclip_n", n_strobe - s0, 3);
`endif

        // reset mid-burst
        bus.plot_en = 1'b0;
        for (int k = 0; k < 10; k++) begin
            drive_px(8'(k + 50), 8'd9, 3'(k), 4);
        end
        check("pre_rst_count", int'(bus.count), 10);
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("rst_mid_count", int'(bus.count), 0);
        check("rst_mid_plot", int'(bus.vga_plot), 0);
        check("rst_mid_empty", int'(bus.empty), 1);
        check("rst_mid_ready", int'(bus.in_ready), 1);
        exp_q.delete();
        @(negedge clk);
        reset       = 1'b0;
        bus.plot_en = 1'b1;
        s0          = n_strobe;
        repeat (20) @(negedge clk);
        check("post_rst_strobes", n_strobe - s0, 0);
        check("post_rst_count", int'(bus.count), 0);

        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end

endmodule
